// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder result checker and the comparison harness.
//   chk_state_t : checker run state
//   DRAIN_CYC   : cycles spent flushing the compare pipeline after stop
//   DEF_WIDTH   : default adder operand/sum width
//   DEF_CNT_W   : default vector/error counter width
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } chk_state_t;

    localparam int unsigned DRAIN_CYC = 2;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, counter to zero
//   clr : synchronous clear (wins over inc)
//   inc : increment by one; holds at all-ones instead of wrapping
//   cnt : current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adder_result_checker.sv
// Result checker placed behind the adder under test. Captures operands and
// the adder result, compares against A+B+cin, counts vectors and mismatches
// and records the first failing vector of each run.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i, stop_i     : run control pulses
//   valid_i             : A_i/B_i/cin_i/SUM_i/cout_i form a vector this cycle
//   busy_o, done_o      : run in progress (RUN/DRAIN), run finished (DONE)
//   fail_o              : sticky, set by the first mismatch of the run
//   vec_cnt_o, err_cnt_o: saturating vector and mismatch counts
//   first_idx_o         : index (from 0) of the first mismatch
//   first_sum_o         : {cout, SUM} of the first mismatch as received
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] SUM_i,
    input  logic             cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] vec_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] first_idx_o,
    output logic [WIDTH:0]   first_sum_o
);

    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYC - 1);

    chk_state_t state_q, state_d;
    logic [1:0] drain_q;
    logic       start_run;

    // Stage 1: raw capture of the vector
    logic             v1;
    logic [WIDTH-1:0] a1, b1;
    logic             cin1;
    logic [WIDTH:0]   res1;

    // Stage 2: compare outcome
    logic             v2;
    logic             mis2;
    logic [WIDTH:0]   res2;

    logic [WIDTH:0]   golden;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (stop_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = DONE;
            end
            DONE: begin
                if (start_i) begin
                    state_d   = RUN;
                    start_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == RUN) || (state_q == DRAIN);
    assign done_o = (state_q == DONE);

    // ---------------- Pipeline ----------------
    always_comb begin
        golden = {1'b0, a1} + {1'b0, b1} + {{WIDTH{1'b0}}, cin1};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            cin1 <= 1'b0;
            res1 <= '0;
            v2   <= 1'b0;
            mis2 <= 1'b0;
            res2 <= '0;
        end else begin
            v1   <= valid_i && (state_q == RUN);
            a1   <= A_i;
            b1   <= B_i;
            cin1 <= cin_i;
            res1 <= {cout_i, SUM_i};
            v2   <= v1;
            mis2 <= (golden != res1);
            res2 <= res1;
        end
    end

    // ---------------- Counters ----------------
    sat_counter #(.W(CNT_W)) u_vec_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (start_run),
        .inc (v2),
        .cnt (vec_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (start_run),
        .inc (v2 && mis2),
        .cnt (err_cnt_o)
    );

    // First-fail capture; index is the vector count before this vector
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_o      <= 1'b0;
            first_idx_o <= '0;
            first_sum_o <= '0;
        end else if (start_run) begin
            fail_o      <= 1'b0;
            first_idx_o <= '0;
            first_sum_o <= '0;
        end else if (v2 && mis2 && !fail_o) begin
            fail_o      <= 1'b1;
            first_idx_o <= vec_cnt_o;
            first_sum_o <= res2;
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
module tb_adder_result_checker;

    logic        clk = 1'b0;
    logic        rst_i, start_i, stop_i, valid_i, cin_i, cout_i;
    logic [31:0] A_i, B_i, SUM_i;

    logic        busy, done, fail;
    logic [15:0] vec_cnt, err_cnt, first_idx;
    logic [32:0] first_sum;

    logic        s_busy, s_done, s_fail;
    logic [3:0]  s_vec_cnt, s_err_cnt, s_first_idx;
    logic [32:0] s_first_sum;

    int checks = 0;
    int errors = 0;

    // Reference model state (unbounded counts, saturated at comparison time)
    bit          armed = 0;
    int          m_vec = 0;
    int          m_err = 0;
    bit          m_fail = 0;
    int          m_idx = 0;
    logic [32:0] m_fsum = '0;

    always #5 clk = ~clk;

    adder_result_checker #(.WIDTH(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .valid_i(valid_i), .A_i(A_i), .B_i(B_i), .cin_i(cin_i),
        .SUM_i(SUM_i), .cout_i(cout_i),
        .busy_o(busy), .done_o(done), .fail_o(fail),
        .vec_cnt_o(vec_cnt), .err_cnt_o(err_cnt),
        .first_idx_o(first_idx), .first_sum_o(first_sum)
    );

    adder_result_checker #(.WIDTH(32), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .valid_i(valid_i), .A_i(A_i), .B_i(B_i), .cin_i(cin_i),
        .SUM_i(SUM_i), .cout_i(cout_i),
        .busy_o(s_busy), .done_o(s_done), .fail_o(s_fail),
        .vec_cnt_o(s_vec_cnt), .err_cnt_o(s_err_cnt),
        .first_idx_o(s_first_idx), .first_sum_o(s_first_sum)
    );

    function automatic logic [63:0] sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return 64'((x > mx) ? mx : x);
    endfunction

    function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic c);
        longint g;
        g = longint'(a) + longint'(b) + longint'(c);
        return g[32:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_vec = 0; m_err = 0; m_fail = 0; m_idx = 0; m_fsum = '0;
    endtask

    // Drives one cycle of stimulus; the model follows the run rules directly.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [32:0] res, input logic vld,
                        input logic stp, input logic stt);
        A_i = a; B_i = b; cin_i = c; {cout_i, SUM_i} = res;
        valid_i = vld; stop_i = stp; start_i = stt;
        if (armed && vld) begin
            if (res != golden(a, b, c)) begin
                if (!m_fail) begin
                    m_fail = 1; m_idx = m_vec; m_fsum = res;
                end
                m_err++;
            end
            m_vec++;
        end
        if (armed && stp) armed = 0;
        else if (!armed && stt) begin
            armed = 1;
            model_clear();
        end
        step();
        valid_i = 0; stop_i = 0; start_i = 0;
    endtask

    task automatic start_run();
        send('0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic rand_vec(input bit bad, input logic stp);
        logic [31:0] a, b;
        logic        c;
        logic [32:0] r;
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
        r = golden(a, b, c);
        if (bad) r = r ^ (33'd1 << $urandom_range(0, 32));
        send(a, b, c, r, 1'b1, stp, 1'b0);
    endtask

    task automatic stop_run();
        send('0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk(tag, 64'(n), 64'd2);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".vec"},  64'(vec_cnt),   sat(m_vec, 16));
        chk({tag, ".err"},  64'(err_cnt),   sat(m_err, 16));
        chk({tag, ".fail"}, 64'(fail),      64'(m_fail));
        chk({tag, ".idx"},  64'(first_idx), sat(m_idx, 16));
        chk({tag, ".fsum"}, 64'(first_sum), 64'(m_fsum));
        chk({tag, ".svec"}, 64'(s_vec_cnt),   sat(m_vec, 4));
        chk({tag, ".serr"}, 64'(s_err_cnt),   sat(m_err, 4));
        chk({tag, ".sfail"}, 64'(s_fail),     64'(m_fail));
        chk({tag, ".sidx"}, 64'(s_first_idx), sat(m_idx, 4));
    endtask

    initial begin
        rst_i = 1; start_i = 0; stop_i = 0; valid_i = 0;
        A_i = '0; B_i = '0; cin_i = 0; SUM_i = '0; cout_i = 0;
        step(); step();
        rst_i = 0;
        step();

        // Reset state
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk_all("rst");

        // IDLE ignores valid and stop
        rand_vec(1, 1'b1);
        rand_vec(1, 1'b0);
        step(); step();
        chk("idle.busy", 64'(busy), 64'd0);
        chk_all("idle");

        // Clean run of 1000 vectors
        start_run();
        chk("clean.busy_rise", 64'(busy), 64'd1);
        for (int i = 0; i < 1000; i++) rand_vec(0, 1'b0);
        stop_run();
        chk("clean.busy_drain", 64'(busy), 64'd1);
        wait_done("clean.done_lat");
        chk("clean.busy_fall", 64'(busy), 64'd0);
        chk("clean.vec_abs", 64'(vec_cnt), 64'd1000);
        chk_all("clean");

        // DONE holds against valid vectors
        for (int i = 0; i < 3; i++) rand_vec(1, 1'b0);
        step(); step();
        chk("donehold.done", 64'(done), 64'd1);
        chk_all("donehold");

        // Carry edge: good then bad carry-out
        start_run();
        send(32'hFFFF_FFFF, 32'h0, 1'b1, {1'b1, 32'h0}, 1'b1, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'h0, 1'b1, {1'b0, 32'h0}, 1'b1, 1'b0, 1'b0);
        stop_run();
        wait_done("carry.done_lat");
        chk("carry.err_abs", 64'(err_cnt), 64'd1);
        chk("carry.fsum_abs", 64'(first_sum), 64'd0);
        chk_all("carry");

        // First-fail capture, start ignored in RUN, stop together with valid
        start_run();
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin
                logic [31:0] a, b;
                a = $urandom; b = $urandom;
                send(a, b, 1'b0, golden(a, b, 1'b0), 1'b1, 1'b0, 1'b1);
            end else begin
                rand_vec((i == 5) || (i == 9), (i == 11) ? 1'b1 : 1'b0);
            end
        end
        rand_vec(1, 1'b0);  // in DRAIN: ignored
        rand_vec(1, 1'b0);  // DRAIN->DONE edge: ignored
        chk("ff.done", 64'(done), 64'd1);
        chk("ff.vec_abs", 64'(vec_cnt), 64'd12);
        chk("ff.err_abs", 64'(err_cnt), 64'd2);
        chk("ff.idx_abs", 64'(first_idx), 64'd5);
        chk_all("ff");

        // Saturation on the narrow-counter instance
        start_run();
        for (int i = 0; i < 20; i++) rand_vec(1, 1'b0);
        stop_run();
        wait_done("sat.done_lat");
        chk("sat.svec_abs", 64'(s_vec_cnt), 64'd15);
        chk("sat.serr_abs", 64'(s_err_cnt), 64'd15);
        chk("sat.sidx_abs", 64'(s_first_idx), 64'd0);
        chk_all("sat");

        // Mid-run reset with two vectors in flight
        start_run();
        rand_vec(1, 1'b0);
        rand_vec(1, 1'b0);
        rst_i = 1;
        armed = 0;
        model_clear();
        #1;
        chk("mrst.busy", 64'(busy), 64'd0);
        chk("mrst.done", 64'(done), 64'd0);
        chk_all("mrst");
        step();
        rst_i = 0;
        step(); step();
        chk_all("mrst.hold");

        // Fresh run after reset
        start_run();
        for (int i = 0; i < 5; i++) rand_vec(i == 3, 1'b0);
        stop_run();
        wait_done("fresh.done_lat");
        chk("fresh.idx_abs", 64'(first_idx), 64'd3);
        chk_all("fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
